// File: rtl/reg_file_dump_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_dump_reader_pkg
//  Purpose  : Shared definitions for the register-file dump reader. Holds the
//             register geometry used by the RF and the datapath, and the dump
//             FSM state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package reg_file_dump_reader_pkg;

  // Register-file geometry shared with the RF and the datapath.
  localparam int c_reg_addr_w = 5;
  localparam int c_reg_data_w = 32;

  // Dump FSM states. The encoding is fixed so the state can be decoded
  // by debug tooling.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } dump_state_e;

  // The reader owns the RF read port exactly while fetching or sending.
  function automatic logic state_is_busy(input dump_state_e s);
    return (s == ST_FETCH) || (s == ST_SEND);
  endfunction

endpackage : reg_file_dump_reader_pkg
`default_nettype wire

// File: rtl/reg_file_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_dump_reader
//  Purpose  : While the core is halted, walks register addresses
//             FIRST_ADDR..LAST_ADDR over one RF read port and streams each
//             (address, value) pair out on a valid/ready handshake, then
//             pulses done. Pulses aborted instead if the core resumes mid-dump.
//  Ports    : clk, rst        clock / synchronous active-high reset
//             start, halted   dump request; core-halted qualifier
//             rf_addr/rf_data RF read address (registered) / combinational data
//             out_valid/ready beat handshake
//             out_addr/data   index and value of the current beat
//             busy            high while fetching or sending
//             done, aborted   one-cycle completion / abort pulses
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file_dump_reader
  import reg_file_dump_reader_pkg::*;
#(
  parameter int ADDR_W     = c_reg_addr_w,
  parameter int DATA_W     = c_reg_data_w,
  parameter int FIRST_ADDR = 0,
  parameter int LAST_ADDR  = 31   // must be >= FIRST_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halted,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,   // signed register content, passed through as-is
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam logic [ADDR_W-1:0] c_first = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(LAST_ADDR);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;

  // Next-state and next-output logic. Every output is a flop; the pulse
  // outputs (done/aborted) default low so they last exactly one cycle.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A start without halted is dropped silently; nothing is queued.
        if (start && halted) begin
          state_d = ST_FETCH;
          idx_d   = c_first;
        end
      end

      ST_FETCH: begin
        // rf_addr has been driven from idx for a full cycle, so rf_data
        // is settled here. A running core means the RF may change under
        // us, so the dump is abandoned without producing a beat.
        if (!halted) begin
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          out_data_d  = rf_data;
          out_addr_d  = idx_q;
          out_valid_d = 1'b1;
          state_d     = ST_SEND;
        end
      end

      ST_SEND: begin
        // The beat is held until accepted even if halted drops meanwhile;
        // a presented beat is never retracted.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (!halted) begin
            aborted_d = 1'b1;
            state_d   = ST_IDLE;
          end else if (idx_q == c_last) begin
            // idx stops at LAST_ADDR, so rf_addr is left pointing there.
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // busy is registered alongside the state so it tracks it exactly.
    busy_d = state_is_busy(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= c_first;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  // The RF read address is the index register itself; no extra flop needed.
  assign rf_addr   = idx_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule : reg_file_dump_reader
`default_nettype wire
